p2s_arbiter: RTL and testbench
==============================

// Module: p2s_arbiter
// PURPOSE
//   Round-robin arbiter sharing one p2s serializer between NREQ parallel sources.
//   Each source has its own valid/ready port. The arbiter grants one source at a time
//   and passes that source's word to the serializer's p_data/p_valid/p_ready port.
//   A watchdog reclaims the grant if the serializer stalls.
// PARAMETERS
//   NUM      8    word width; equals the NUM of the attached p2s
//   NREQ     4    number of requesters, 2..16
//   TIMEOUT  64   max cycles in SEND without a handshake; 0 disables the watchdog
//   IDW      $clog2(NREQ)  localparam, grant index width
// PORTS
//   clk        in   1         clock, rising edge
//   rstn       in   1         asynchronous active-low reset
//   req_data   in   NREQ*NUM  requester words; requester i occupies bits [i*NUM +: NUM]
//   req_valid  in   NREQ      requester i has a word
//   req_ready  out  NREQ      requester i's word is taken this cycle
//   p_data     out  NUM       word to the serializer
//   p_valid    out  1         serializer word valid
//   p_ready    in   1         serializer can take a word
//   grant_id   out  IDW       index of the current/last granted requester
//   busy       out  1         high while in SEND
//   timeout    out  1         one-cycle pulse when the watchdog fires
// BEHAVIOUR
//   Reset (async, rstn=0): state=IDLE, ptr=0, grant_id=0, busy=0, timeout=0, wdog=0.
//     Outputs are combinational from state, so p_valid=0 and req_ready=0 during reset.
//   Reset mid-SEND: the grant is dropped immediately, no word is transferred,
//     and the source keeps its req_valid.
//   FSM states: IDLE, SEND.
//   IDLE:
//     - p_valid=0, req_ready=0.
//     - If any req_valid is high, pick the first set bit searching ptr, ptr+1, ... (mod NREQ).
//     - Register the winner in grant_id and go to SEND on the next edge.
//   SEND:
//     - p_data  = req_data[grant_id]
//     - p_valid = req_valid[grant_id]
//     - req_ready[grant_id] = p_ready; all other req_ready bits are 0
//     - Only the granted requester's data, valid and ready are passed through combinationally.
//   Handshake (p_valid & p_ready):
//     - ptr <= grant_id+1 (mod NREQ) and state returns to IDLE.
//     - Exception: with lock enabled, stay in SEND (see CONFIGURATION).
//   Throughput: 2 cycles per word without lock. This is far below serializer service time (NUM+1).
//   Withdrawal: req_valid[grant_id]=0 in SEND with no handshake -> IDLE, ptr <= grant_id+1.
//     The requester forfeits its turn.
//   Watchdog:
//     - wdog counts SEND cycles without a handshake, cleared on entering SEND and on every handshake.
//     - If TIMEOUT!=0 and wdog==TIMEOUT-1 with no handshake that cycle: timeout=1 for one cycle,
//       state -> IDLE, ptr <= grant_id+1.
//   Same-cycle events: a handshake takes priority over both withdrawal and timeout.
//   Arbitration latency: the first request raised in IDLE is presented to the serializer on the next cycle.
//   ptr wrap-around: ptr = NREQ-1 wraps to 0. The search covers all NREQ bits in one cycle.
//   grant_id holds its value in IDLE. busy = (state==SEND).
// CONFIGURATION
//   P2S_ARB_LOCK_EN defined:
//     - Adds input port req_lock [NREQ].
//     - On a handshake with req_lock[grant_id]=1, stay in SEND with the same grant_id.
//       ptr is unchanged and wdog is cleared.
//     - Back-to-back words are possible (1 cycle per word).
//   P2S_ARB_LOCK_EN undefined:
//     - No req_lock port.
//     - Every handshake returns to IDLE and rotates priority.
// TESTING  (NUM=8, NREQ=4, TIMEOUT=16)
//   1. Hold rstn=0 with req_valid=4'hF.
//      -> p_valid=0, req_ready=0, busy=0, grant_id=0.
//      Release rstn: SEND with grant_id=0 one cycle later.
//   2. Only req 2 valid with 8'd63, p_ready=1.
//      -> Next cycle: grant_id=2, p_data=63, req_ready=4'b0100.
//      -> Then IDLE; next request from 3 and from 0 arriving together -> 3 wins.
//   3. req_valid=4'hF held, p_ready=1.
//      -> Grants 0,1,2,3,0 in order; one handshake every 2 cycles; no source is granted twice before all four.
//   4. Req 1 granted with 8'd52, p_ready=0 for 3 cycles then 1.
//      -> p_valid=1 and p_data=52 stable throughout; req_ready[1]=0 until p_ready rises;
//         exactly one handshake.
//   5. Req 0 granted, p_ready=0 for 20 cycles.
//      -> timeout pulse on the 16th SEND cycle, then IDLE.
//      -> Req 1 granted next if valid; req_ready[0] never asserted.
//   6. P2S_ARB_LOCK_EN defined: req 1 sends 3 words with req_lock[1]=1 while req 2 is valid.
//      -> Three consecutive handshakes from req 1, then req 2.
//      Without the macro -> order is 1,2,...

Source files
------------

// File: rtl/p2s_arbiter.sv
// p2s_arbiter
//   Round-robin arbiter that shares one p2s serializer between NREQ parallel
//   sources. In IDLE it picks the first requester at or after the rotating
//   priority pointer. In SEND it connects only that requester's data, valid
//   and ready straight through to the serializer. A watchdog reclaims the
//   grant if the serializer stalls for TIMEOUT cycles.
//
// Optional feature macro: P2S_ARB_LOCK_EN
//   When defined, the module gains a req_lock port. A handshake with
//   req_lock[grant_id]=1 keeps the same grant, so back-to-back words can be
//   sent at one word per cycle.
//
// Parameters
//   NUM      word width (matches the attached p2s)
//   NREQ     number of requesters, 2..16
//   TIMEOUT  SEND cycles without a handshake before the grant is reclaimed;
//            0 disables the watchdog
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   req_data   in   NREQ*NUM  requester i word at [i*NUM +: NUM]
//   req_valid  in   NREQ      requester i has a word
//   req_lock   in   NREQ      (P2S_ARB_LOCK_EN only) keep grant after handshake
//   req_ready  out  NREQ      requester i's word is taken this cycle
//   p_data     out  NUM       word to the serializer
//   p_valid    out  1         serializer word valid
//   p_ready    in   1         serializer can take a word
//   grant_id   out  IDW       current / last granted requester
//   busy       out  1         high while in SEND
//   timeout    out  1         one-cycle pulse when the watchdog fires
module p2s_arbiter #(
  parameter int NUM     = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ*NUM-1:0] req_data,
  input  logic [NREQ-1:0]     req_valid,
`ifdef P2S_ARB_LOCK_EN
  input  logic [NREQ-1:0]     req_lock,
`endif
  output logic [NREQ-1:0]     req_ready,
  output logic [NUM-1:0]      p_data,
  output logic                p_valid,
  input  logic                p_ready,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic                timeout
);

  // The watchdog only needs to count up to TIMEOUT-1.
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grant_next;
  logic           found;
  logic           hs;
  logic           lock_hold;
  logic           wdog_expired;
  int             sum;

`ifdef P2S_ARB_LOCK_EN
  assign lock_hold = req_lock[grant_q];
`else
  assign lock_hold = 1'b0;
`endif

  // Priority moves to the requester after the one just served, wrapping at NREQ-1.
  assign grant_next = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT - 1));

  assign busy     = (state_q == SEND);
  assign grant_id = grant_q;

  // Rotating search over all NREQ bits in one cycle: candidates are visited
  // in the order ptr, ptr+1, ... modulo NREQ and the first valid one wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    sum    = 0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      cand = IDW'(sum);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state and pass-through outputs. A handshake outranks both the
  // watchdog and a withdrawal. If the watchdog and a withdrawal coincide,
  // the timeout pulse is still reported.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    wdog_d    = wdog_q;
    p_data    = '0;
    p_valid   = 1'b0;
    req_ready = '0;
    hs        = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          wdog_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        p_data             = req_data[int'(grant_q)*NUM +: NUM];
        p_valid            = req_valid[grant_q];
        req_ready[grant_q] = p_ready;
        hs                 = p_valid & p_ready;

        if (hs) begin
          wdog_d = '0;
          if (!lock_hold) begin
            state_d = IDLE;
            ptr_d   = grant_next;
          end
        end else if (wdog_expired) begin
          timeout = 1'b1;
          state_d = IDLE;
          ptr_d   = grant_next;
        end else if (!p_valid) begin
          state_d = IDLE;
          ptr_d   = grant_next;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_p2s_arbiter.sv
// tb_p2s_arbiter
//   Self-checking bench for p2s_arbiter (NUM=8, NREQ=4, TIMEOUT=16).
//   A transaction-level model tracks who holds the grant, the rotating
//   priority and how long the current grant has waited. One compare process
//   checks every DUT output against it on each falling edge. Directed
//   scenarios pin the model with hand-computed values, and a randomized
//   phase then exercises stalls, withdrawals, locks and timeouts.
//   Build with +define+P2S_ARB_LOCK_EN to cover the lock feature.
module tb_p2s_arbiter;

  localparam int NUM     = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
`ifdef P2S_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                clk;
  logic                rstn;
  logic [NREQ*NUM-1:0] req_data;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_lock;
  logic [NREQ-1:0]     req_ready;
  logic [NUM-1:0]      p_data;
  logic                p_valid;
  logic                p_ready;
  logic [1:0]          grant_id;
  logic                busy;
  logic                timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Words each source still has to send, including the one on req_data.
  int pending [NREQ];

  // Handshakes observed on the DUT: requester index and cycle number.
  int log_id [$];
  int log_cyc [$];

  // Model state: grant held or not, granted index, priority pointer and the
  // number of SEND cycles spent on the current word (1 = first cycle).
  bit m_busy = 1'b0;
  int m_gnt  = 0;
  int m_ptr  = 0;
  int m_wait = 0;

  p2s_arbiter #(
    .NUM     (NUM),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_data  (req_data),
    .req_valid (req_valid),
`ifdef P2S_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // First valid requester in round-robin order starting at 'start', or -1.
  function automatic int first_valid(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit model_hs();
    return m_busy && req_valid[m_gnt] && p_ready;
  endfunction

  function automatic bit model_timeout();
    return m_busy && !model_hs() && (TIMEOUT != 0) && (m_wait == TIMEOUT);
  endfunction

  function automatic int log_at(input int i);
    if (i < log_id.size()) return log_id[i];
    return -1;
  endfunction

  // The model advances on each rising edge, and reset drops the grant at once.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0;
      m_gnt  <= 0;
      m_ptr  <= 0;
      m_wait <= 0;
    end else if (!m_busy) begin
      if (first_valid(req_valid, m_ptr) >= 0) begin
        m_busy <= 1'b1;
        m_gnt  <= first_valid(req_valid, m_ptr);
        m_wait <= 1;
      end
    end else if (model_hs()) begin
      if (LOCK && req_lock[m_gnt]) begin
        m_wait <= 1;
      end else begin
        m_busy <= 1'b0;
        m_ptr  <= (m_gnt + 1) % NREQ;
      end
    end else if (model_timeout() || !req_valid[m_gnt]) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_gnt + 1) % NREQ;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every falling edge: all outputs against the model.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("busy", int'(busy), int'(m_busy));
      check("grant_id", int'(grant_id), m_gnt);
      check("p_valid", int'(p_valid), int'(m_busy && req_valid[m_gnt]));
      check("req_ready", int'(req_ready), (m_busy && p_ready) ? (1 << m_gnt) : 0);
      check("timeout", int'(timeout), int'(model_timeout()));
      if (m_busy && req_valid[m_gnt]) begin
        check("p_data", int'(p_data), int'(req_data[m_gnt*NUM +: NUM]));
      end
    end
  endtask

  task automatic load(input int i, input int n, input logic [NUM-1:0] d);
    pending[i]           = n;
    req_data[i*NUM +: NUM] = d;
    req_valid[i]         = 1'b1;
  endtask

  task automatic drop(input int i);
    pending[i]   = 0;
    req_valid[i] = 1'b0;
  endtask

  // One clock: log a handshake, then let sources whose word was taken present
  // their next word or go quiet.
  task automatic step();
    logic [NREQ-1:0] taken;
    @(negedge clk);
    taken = req_valid & req_ready;
    if (p_valid && p_ready) begin
      log_id.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (taken[i]) begin
        pending[i]--;
        if (pending[i] > 0) req_data[i*NUM +: NUM] = NUM'($urandom);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic apply_stimulus();
    int base;
    int n;
    bit idle_all;
    // 1: reset holds everything quiet even with all sources requesting.
    rstn      = 1'b0;
    p_ready   = 1'b0;
    req_lock  = '0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) load(i, 1, NUM'(8'h10 + i));
    step();
    step();
    #1;
    check("rst_p_valid", int'(p_valid), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    rstn = 1'b1;
    step();
    #1;
    check("t1_busy", int'(busy), 1);
    check("t1_grant", int'(grant_id), 0);
    for (int i = 0; i < NREQ; i++) drop(i);
    step();
    #1;
    check("t1_withdraw_idle", int'(busy), 0);

    // 2: single requester with a known word, then 3 beats 0 on rotation.
    load(2, 1, 8'd63);
    p_ready = 1'b1;
    step();
    #1;
    check("t2_grant", int'(grant_id), 2);
    check("t2_p_data", int'(p_data), 63);
    check("t2_req_ready", int'(req_ready), 4'b0100);
    step();
    load(3, 1, 8'h33);
    load(0, 1, 8'h44);
    step();
    #1;
    check("t2_rr_grant", int'(grant_id), 3);
    step();
    step();
    step();
    load(3, 1, 8'h55);
    step();
    step();

    // 3: all four requesting, two words each, starting from pointer 0.
    base = log_id.size();
    for (int i = 0; i < NREQ; i++) load(i, 2, NUM'($urandom));
    n = 0;
    do begin
      step();
      n++;
      idle_all = 1'b1;
      for (int i = 0; i < NREQ; i++) if (pending[i] != 0) idle_all = 1'b0;
    end while (!idle_all && n < 40);
    check("t3_drained", int'(idle_all), 1);
    check("t3_count", log_id.size() - base, 8);
    check("t3_order0", log_at(base + 0), 0);
    check("t3_order1", log_at(base + 1), 1);
    check("t3_order2", log_at(base + 2), 2);
    check("t3_order3", log_at(base + 3), 3);
    check("t3_order4", log_at(base + 4), 0);
    if (log_cyc.size() >= base + 8) begin
      for (int i = 1; i < 8; i++) begin
        check("t3_spacing", log_cyc[base + i] - log_cyc[base + i - 1], 2);
      end
    end

    // 4: serializer stalls for three cycles on requester 1.
    base = log_id.size();
    p_ready = 1'b0;
    load(1, 1, 8'd52);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_p_valid", int'(p_valid), 1);
      check("t4_p_data", int'(p_data), 52);
      check("t4_req_ready_low", int'(req_ready), 0);
      step();
    end
    p_ready = 1'b1;
    #1;
    check("t4_req_ready", int'(req_ready), 4'b0010);
    step();
    step();
    check("t4_one_hs", log_id.size() - base, 1);
    check("t4_hs_id", log_at(base), 1);

    // 5: watchdog fires on the 16th stalled SEND cycle of requester 0.
    base = log_id.size();
    p_ready = 1'b0;
    load(0, 1, 8'hA5);
    load(1, 1, 8'h5A);
    step();
    for (int c = 1; c <= 16; c++) begin
      #1;
      check("t5_timeout", int'(timeout), int'(c == 16));
      check("t5_ready0", int'(req_ready), 0);
      step();
    end
    #1;
    check("t5_idle", int'(busy), 0);
    step();
    #1;
    check("t5_next_grant", int'(grant_id), 1);
    step();
    step();
    p_ready = 1'b1;
    step();
    step();
    step();
    check("t5_hs_first", log_at(base), 1);
    check("t5_hs_second", log_at(base + 1), 0);

    // 6: requester 1 sends three words while 2 waits.
    base = log_id.size();
    load(1, 3, 8'h11);
    load(2, 1, 8'h22);
    req_lock = 4'b0010;
    n = 0;
    do begin
      step();
      n++;
    end while ((pending[1] != 0 || pending[2] != 0) && n < 30);
    req_lock = '0;
    check("t6_first", log_at(base), 1);
    if (LOCK) begin
      check("t6_lock1", log_at(base + 1), 1);
      check("t6_lock2", log_at(base + 2), 1);
      check("t6_then2", log_at(base + 3), 2);
    end else begin
      check("t6_rotate", log_at(base + 1), 2);
    end
    step();
    step();

    // Reset in the middle of SEND drops the grant; the source keeps waiting.
    p_ready = 1'b0;
    load(2, 1, 8'h77);
    step();
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_p_valid", int'(p_valid), 0);
    check("mid_rst_grant", int'(grant_id), 0);
    step();
    rstn = 1'b1;
    step();
    #1;
    check("mid_rst_regrant", int'(grant_id), 2);
    p_ready = 1'b1;
    step();
    step();

    // Random traffic; the second half stalls the serializer heavily.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          load(i, int'($urandom_range(1, 3)), NUM'($urandom));
        end
      end
      if ($urandom_range(0, 19) == 0) drop(int'($urandom_range(0, NREQ - 1)));
      if (t < 200) p_ready = ($urandom_range(0, 3) != 0);
      else p_ready = ($urandom_range(0, 9) == 0);
      req_lock = NREQ'($urandom);
      step();
    end
  endtask

  initial begin
    fork
      compare_loop();
    join_none
    apply_stimulus();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
